// File: rtl/commit_regfile_if.sv
// Commit-stage port bundle for the architectural register file: two GPR writes,
// HI/LO and LLbit updates, and four independent combinational GPR read ports.
interface commit_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we1_i;
    logic [ADDR_W-1:0] waddr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              we2_i;
    logic [ADDR_W-1:0] waddr2_i;
    logic [DATA_W-1:0] wdata2_i;
    logic              whilo_i;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic              LLbit_we_i;
    logic              LLbit_i;
    logic              llclr_i;
    logic              re0_i;
    logic              re1_i;
    logic              re2_i;
    logic              re3_i;
    logic [ADDR_W-1:0] raddr0_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [ADDR_W-1:0] raddr3_i;
    logic [DATA_W-1:0] rdata0_o;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;
    logic [DATA_W-1:0] rdata3_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              LLbit_o;

    modport master (
        output we1_i, waddr1_i, wdata1_i, we2_i, waddr2_i, wdata2_i,
        output whilo_i, hi_i, lo_i, LLbit_we_i, LLbit_i, llclr_i,
        output re0_i, re1_i, re2_i, re3_i, raddr0_i, raddr1_i, raddr2_i, raddr3_i,
        input  rdata0_o, rdata1_o, rdata2_o, rdata3_o, hi_o, lo_o, LLbit_o
    );

    modport slave (
        input  we1_i, waddr1_i, wdata1_i, we2_i, waddr2_i, wdata2_i,
        input  whilo_i, hi_i, lo_i, LLbit_we_i, LLbit_i, llclr_i,
        input  re0_i, re1_i, re2_i, re3_i, raddr0_i, raddr1_i, raddr2_i, raddr3_i,
        output rdata0_o, rdata1_o, rdata2_o, rdata3_o, hi_o, lo_o, LLbit_o
    );
endinterface

// File: rtl/commit_regfile.sv
// Architectural GPR/HI/LO/LLbit store fed by a dual-issue commit stage.
// Writes land on the next clk edge; reads are combinational with same-cycle bypass; no back-pressure.
// Reads of $0 are always zero and everything reads zero while in reset.
module commit_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    commit_regfile_if.slave  rf
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              ll_q;

    // Forwarding is disabled while in reset so every output reads zero.
    logic byp_on;
    assign byp_on = (BYPASS != 0) && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
            ll_q <= 1'b0;
        end else begin
            // Slot2 is the younger instruction, so its write is placed last and wins a collision.
            if (rf.we1_i && (rf.waddr1_i != '0)) begin
                gpr[rf.waddr1_i] <= rf.wdata1_i;
            end
            if (rf.we2_i && (rf.waddr2_i != '0)) begin
                gpr[rf.waddr2_i] <= rf.wdata2_i;
            end
            if (rf.whilo_i) begin
                hi_q <= rf.hi_i;
                lo_q <= rf.lo_i;
            end
            if (rf.llclr_i) begin
                ll_q <= 1'b0;
            end else if (rf.LLbit_we_i) begin
                ll_q <= rf.LLbit_i;
            end
        end
    end

    logic              re_v [4];
    logic [ADDR_W-1:0] ra_v [4];
    logic [DATA_W-1:0] rd_v [4];

    assign re_v[0] = rf.re0_i;
    assign re_v[1] = rf.re1_i;
    assign re_v[2] = rf.re2_i;
    assign re_v[3] = rf.re3_i;
    assign ra_v[0] = rf.raddr0_i;
    assign ra_v[1] = rf.raddr1_i;
    assign ra_v[2] = rf.raddr2_i;
    assign ra_v[3] = rf.raddr3_i;

    for (genvar n = 0; n < 4; n++) begin : g_rd
        logic hit1;
        logic hit2;
        assign hit1 = byp_on && rf.we1_i && (rf.waddr1_i == ra_v[n]);
        assign hit2 = byp_on && rf.we2_i && (rf.waddr2_i == ra_v[n]);

        always_comb begin
            rd_v[n] = '0;
            if (rst && re_v[n] && (ra_v[n] != '0)) begin
                if (hit2) begin
                    rd_v[n] = rf.wdata2_i;
                end else if (hit1) begin
                    rd_v[n] = rf.wdata1_i;
                end else begin
                    rd_v[n] = gpr[ra_v[n]];
                end
            end
        end
    end

    assign rf.rdata0_o = rd_v[0];
    assign rf.rdata1_o = rd_v[1];
    assign rf.rdata2_o = rd_v[2];
    assign rf.rdata3_o = rd_v[3];

    always_comb begin
        rf.hi_o    = '0;
        rf.lo_o    = '0;
        rf.LLbit_o = 1'b0;
        if (rst) begin
            rf.hi_o    = (byp_on && rf.whilo_i) ? rf.hi_i : hi_q;
            rf.lo_o    = (byp_on && rf.whilo_i) ? rf.lo_i : lo_q;
            if (byp_on && rf.llclr_i) begin
                rf.LLbit_o = 1'b0;
            end else if (byp_on && rf.LLbit_we_i) begin
                rf.LLbit_o = rf.LLbit_i;
            end else begin
                rf.LLbit_o = ll_q;
            end
        end
    end
endmodule

// File: tb/tb_commit_regfile.sv
// Directed bench for commit_regfile: one bypassing instance (a) and one array-only instance (b)
// driven with identical inputs, checked with immediate assertions.
module tb_commit_regfile;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    commit_regfile_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    commit_regfile_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    commit_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .rf(ifa.slave));
    commit_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .rf(ifb.slave));

    assign ifb.we1_i      = ifa.we1_i;
    assign ifb.waddr1_i   = ifa.waddr1_i;
    assign ifb.wdata1_i   = ifa.wdata1_i;
    assign ifb.we2_i      = ifa.we2_i;
    assign ifb.waddr2_i   = ifa.waddr2_i;
    assign ifb.wdata2_i   = ifa.wdata2_i;
    assign ifb.whilo_i    = ifa.whilo_i;
    assign ifb.hi_i       = ifa.hi_i;
    assign ifb.lo_i       = ifa.lo_i;
    assign ifb.LLbit_we_i = ifa.LLbit_we_i;
    assign ifb.LLbit_i    = ifa.LLbit_i;
    assign ifb.llclr_i    = ifa.llclr_i;
    assign ifb.re0_i      = ifa.re0_i;
    assign ifb.re1_i      = ifa.re1_i;
    assign ifb.re2_i      = ifa.re2_i;
    assign ifb.re3_i      = ifa.re3_i;
    assign ifb.raddr0_i   = ifa.raddr0_i;
    assign ifb.raddr1_i   = ifa.raddr1_i;
    assign ifb.raddr2_i   = ifa.raddr2_i;
    assign ifb.raddr3_i   = ifa.raddr3_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, returning half a cycle later with inputs safe to change.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_writes();
        ifa.we1_i = 1'b0; ifa.we2_i = 1'b0; ifa.whilo_i = 1'b0;
        ifa.LLbit_we_i = 1'b0; ifa.llclr_i = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        clear_writes();
        ifa.waddr1_i = '0; ifa.wdata1_i = '0; ifa.waddr2_i = '0; ifa.wdata2_i = '0;
        ifa.hi_i = '0; ifa.lo_i = '0; ifa.LLbit_i = 1'b0;
        ifa.re0_i = 1'b0; ifa.re1_i = 1'b0; ifa.re2_i = 1'b0; ifa.re3_i = 1'b0;
        ifa.raddr0_i = '0; ifa.raddr1_i = '0; ifa.raddr2_i = '0; ifa.raddr3_i = '0;

        // Reset: outputs zero, writes and forwarding suppressed.
        ifa.re0_i = 1'b1; ifa.raddr0_i = 5'd5;
        #1;
        chk("rst_rdata0_a", ifa.rdata0_o, 32'h0);
        chk("rst_hi_a", ifa.hi_o, 32'h0);
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd5; ifa.wdata1_i = 32'hCAFE_F00D;
        ifa.whilo_i = 1'b1; ifa.hi_i = 32'h7; ifa.lo_i = 32'h8;
        ifa.LLbit_we_i = 1'b1; ifa.LLbit_i = 1'b1;
        #1;
        chk("rst_byp_rdata0_a", ifa.rdata0_o, 32'h0);
        chk("rst_byp_lo_a", ifa.lo_o, 32'h0);
        chk("rst_byp_ll_a", {31'b0, ifa.LLbit_o}, 32'h0);
        step();
        step();
        clear_writes();
        rst = 1'b1;
        #1;
        chk("post_rst_rdata0_a", ifa.rdata0_o, 32'h0);
        chk("post_rst_rdata0_b", ifb.rdata0_o, 32'h0);
        chk("post_rst_hi_a", ifa.hi_o, 32'h0);
        chk("post_rst_ll_a", {31'b0, ifa.LLbit_o}, 32'h0);

        // Write and readback on slot1.
        step();
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd3; ifa.wdata1_i = 32'h1234_5678;
        ifa.re1_i = 1'b1; ifa.raddr1_i = 5'd3;
        #1;
        chk("wr3_byp_a", ifa.rdata1_o, 32'h1234_5678);
        chk("wr3_byp_b", ifb.rdata1_o, 32'h0);
        step();
        clear_writes();
        #1;
        chk("wr3_rd_a", ifa.rdata1_o, 32'h1234_5678);
        chk("wr3_rd_b", ifb.rdata1_o, 32'h1234_5678);

        // $0 write is dropped and never forwarded.
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd0; ifa.wdata1_i = 32'hFFFF_FFFF;
        ifa.raddr0_i = 5'd0;
        #1;
        chk("r0_byp_a", ifa.rdata0_o, 32'h0);
        step();
        clear_writes();
        #1;
        chk("r0_rd_a", ifa.rdata0_o, 32'h0);
        chk("r0_rd_b", ifb.rdata0_o, 32'h0);

        // Same-address collision: younger slot2 wins both bypass and storage.
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd7; ifa.wdata1_i = 32'hAAAA_AAAA;
        ifa.we2_i = 1'b1; ifa.waddr2_i = 5'd7; ifa.wdata2_i = 32'h5555_5555;
        ifa.re2_i = 1'b1; ifa.raddr2_i = 5'd7;
        #1;
        chk("col_byp_a", ifa.rdata2_o, 32'h5555_5555);
        chk("col_byp_b", ifb.rdata2_o, 32'h0);
        step();
        clear_writes();
        #1;
        chk("col_rd_a", ifa.rdata2_o, 32'h5555_5555);
        chk("col_rd_b", ifb.rdata2_o, 32'h5555_5555);

        // Independent slot bypasses on different ports.
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd10; ifa.wdata1_i = 32'h1111_2222;
        ifa.we2_i = 1'b1; ifa.waddr2_i = 5'd9;  ifa.wdata2_i = 32'hDEAD_BEEF;
        ifa.raddr2_i = 5'd9;
        ifa.re3_i = 1'b1; ifa.raddr3_i = 5'd10;
        ifa.raddr1_i = 5'd3;
        #1;
        chk("byp2_a", ifa.rdata2_o, 32'hDEAD_BEEF);
        chk("byp2_b", ifb.rdata2_o, 32'h0);
        chk("byp1_a", ifa.rdata3_o, 32'h1111_2222);
        chk("byp1_b", ifb.rdata3_o, 32'h0);
        chk("nohit_a", ifa.rdata1_o, 32'h1234_5678);
        step();
        clear_writes();
        #1;
        chk("st9_b", ifb.rdata2_o, 32'hDEAD_BEEF);
        chk("st10_b", ifb.rdata3_o, 32'h1111_2222);
        ifa.re3_i = 1'b0;
        #1;
        chk("re0_gate_a", ifa.rdata3_o, 32'h0);

        // HI/LO forwarded, then held.
        ifa.whilo_i = 1'b1; ifa.hi_i = 32'h1; ifa.lo_i = 32'h2;
        #1;
        chk("hi_byp_a", ifa.hi_o, 32'h1);
        chk("lo_byp_a", ifa.lo_o, 32'h2);
        chk("hi_byp_b", ifb.hi_o, 32'h0);
        step();
        clear_writes();
        ifa.hi_i = 32'h99; ifa.lo_i = 32'h98;
        #1;
        chk("hi_hold_a", ifa.hi_o, 32'h1);
        chk("lo_hold_b", ifb.lo_o, 32'h2);

        // LLbit set, then clear beats a simultaneous set.
        ifa.LLbit_we_i = 1'b1; ifa.LLbit_i = 1'b1;
        #1;
        chk("ll_set_a", {31'b0, ifa.LLbit_o}, 32'h1);
        chk("ll_set_b", {31'b0, ifb.LLbit_o}, 32'h0);
        step();
        clear_writes();
        #1;
        chk("ll_st_b", {31'b0, ifb.LLbit_o}, 32'h1);
        ifa.llclr_i = 1'b1; ifa.LLbit_we_i = 1'b1; ifa.LLbit_i = 1'b1;
        #1;
        chk("ll_clr_a", {31'b0, ifa.LLbit_o}, 32'h0);
        chk("ll_clr_b", {31'b0, ifb.LLbit_o}, 32'h1);
        step();
        clear_writes();
        #1;
        chk("ll_clr_st_b", {31'b0, ifb.LLbit_o}, 32'h0);

        // Reset during a write loses that write and clears prior state.
        ifa.we1_i = 1'b1; ifa.waddr1_i = 5'd12; ifa.wdata1_i = 32'h0BAD_0BAD;
        rst = 1'b0;
        step();
        clear_writes();
        rst = 1'b1;
        ifa.re0_i = 1'b1; ifa.raddr0_i = 5'd12;
        ifa.raddr1_i = 5'd3;
        #1;
        chk("midrst_lost_b", ifb.rdata0_o, 32'h0);
        chk("midrst_clr3_b", ifb.rdata1_o, 32'h0);
        chk("midrst_hi_b", ifb.hi_o, 32'h0);
        ifa.we1_i = 1'b1; ifa.wdata1_i = 32'h0F0F_0F0F;
        step();
        clear_writes();
        #1;
        chk("first_edge_a", ifa.rdata0_o, 32'h0F0F_0F0F);
        chk("first_edge_b", ifb.rdata0_o, 32'h0F0F_0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
